// File: rtl/add32_share_arb.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters.
// Optional macro ADD_ARB_CARRY_EN adds a registered carry-out (rsp_carry) to the response.
module add32_share_arb #(
    parameter  int NREQ = 2,
    parameter  int W    = 32,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_q
`ifdef ADD_ARB_CARRY_EN
    ,
    output logic              rsp_carry
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [W-1:0]    op_a_q, op_b_q;
    logic [W-1:0]    res_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] gnt_oh;
    logic [W-1:0]    gnt_a, gnt_b;
    logic [IDW-1:0]  rr_ptr_d;
    int              idx;

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(rr_ptr_q) + k) % NREQ;
            cand = IDW'(idx);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_oh = '0;
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
        gnt_a = req_a[int'(gnt_idx)*W +: W];
        gnt_b = req_b[int'(gnt_idx)*W +: W];
    end

    assign rr_ptr_d  = (rsp_id_q == IDW'(NREQ-1)) ? '0 : rsp_id_q + IDW'(1);

    // Grants are suppressed while reset is asserted so no handshake completes then.
    assign req_ready = (state_q == IDLE && rst_n) ? gnt_oh : '0;
    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = res_q;

`ifdef ADD_ARB_CARRY_EN
    logic carry_q;
    logic carry_d;
    assign carry_d   = 1'(({1'b0, op_a_q} + {1'b0, op_b_q}) >> W);
    assign rsp_carry = carry_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
`ifdef ADD_ARB_CARRY_EN
            carry_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_a_q   <= gnt_a;
                        op_b_q   <= gnt_b;
                        rsp_id_q <= gnt_idx;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= add_q;
                    rsp_valid_q <= 1'b1;
`ifdef ADD_ARB_CARRY_EN
                    carry_q     <= carry_d;
`endif
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
